// File: rtl/tych_rx_pktbuf_pkg.sv
// Shared types and default sizing for the tych receive packet buffer.
package tych_rx_pktbuf_pkg;

    localparam int TYCH_RXBUF_DEPTH = 512;
    localparam int RXBUF_DWIDTH     = 64;
    localparam int RXBUF_EMPTY_W    = 3;

    typedef struct packed {
        logic [RXBUF_DWIDTH-1:0]  data;
        logic                     sop;
        logic                     eop;
        logic [RXBUF_EMPTY_W-1:0] empty;
    } rxbuf_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rxbuf_wstate_t;

endpackage

// File: rtl/tych_rx_pktbuf_if.sv
// MAC-side beat stream (no backpressure) plus the downstream valid/ready stream.
// Downstream: a beat moves when out_valid && out_ready at a rising edge; while out_valid=1 and out_ready=0 every out_* field holds.
interface tych_rx_pktbuf_if
    import tych_rx_pktbuf_pkg::*;
#(
    parameter int DWIDTH  = RXBUF_DWIDTH,
    parameter int EMPTY_W = RXBUF_EMPTY_W
);
    logic               in_valid;
    logic [DWIDTH-1:0]  in_data;
    logic               in_sop;
    logic               in_eop;
    logic [EMPTY_W-1:0] in_empty;
    logic               in_error;
    logic               out_valid;
    logic               out_ready;
    logic [DWIDTH-1:0]  out_data;
    logic               out_sop;
    logic               out_eop;
    logic [EMPTY_W-1:0] out_empty;

    modport master (
        output in_valid, in_data, in_sop, in_eop, in_empty, in_error, out_ready,
        input  out_valid, out_data, out_sop, out_eop, out_empty
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, in_empty, in_error, out_ready,
        output out_valid, out_data, out_sop, out_eop, out_empty
    );
endinterface

// File: rtl/tych_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered 1-cycle read data.
module tych_sdp_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 69
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/tych_rx_pktbuf.sv
// Store-and-forward receive buffer: commits only complete error-free packets,
// then streams them out with valid/ready through a two-deep prefetch stage.
module tych_rx_pktbuf
    import tych_rx_pktbuf_pkg::*;
#(
    parameter int DWIDTH  = RXBUF_DWIDTH,
    parameter int EMPTY_W = RXBUF_EMPTY_W,
    parameter int DEPTH   = TYCH_RXBUF_DEPTH,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    tych_rx_pktbuf_if.slave          bus,
    output logic [CNT_W-1:0]         stat_pkt_cnt,
    output logic [CNT_W-1:0]         stat_drop_cnt,
    output logic [CNT_W-1:0]         stat_err_cnt,
    output rxbuf_wstate_t            dbg_wstate,
    output logic [$clog2(DEPTH):0]   dbg_used
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]    FULL_LVL = PW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef struct packed {
        logic [DWIDTH-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } entry_t;

    rxbuf_wstate_t state, state_n;
    logic [PW-1:0] wr_ptr, wr_ptr_n, wr_commit, commit_n, rd_ptr, fetch_ptr;
    logic          wr_en, inc_pkt, inc_drop;
    logic [1:0]    err_inc;
    logic [AW-1:0] wr_addr;
    logic          full_wr, full_commit;
    entry_t        wr_entry, ram_q, out_q, skid_q;
    logic          ram_vld, out_v, skid_v, pop, rd_issue;

    // rd_ptr only advances on delivery, so beats sitting in the prefetch stage still count as used.
    assign full_wr     = (wr_ptr - rd_ptr) == FULL_LVL;
    assign full_commit = (wr_commit - rd_ptr) == FULL_LVL;
    assign wr_entry    = '{data: bus.in_data, sop: bus.in_sop, eop: bus.in_eop, empty: bus.in_empty};

    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        commit_n = wr_commit;
        wr_en    = 1'b0;
        wr_addr  = wr_ptr[AW-1:0];
        inc_pkt  = 1'b0;
        inc_drop = 1'b0;
        err_inc  = 2'd0;
        if (bus.in_valid) begin
            if (bus.in_sop) begin
                // Any sop restarts from the committed pointer; an open packet is abandoned.
                if (state == RECV) err_inc = 2'd1;
                wr_ptr_n = wr_commit;
                wr_addr  = wr_commit[AW-1:0];
                if (full_commit) begin
                    inc_drop = 1'b1;
                    state_n  = bus.in_eop ? IDLE : DROP;
                end else if (bus.in_eop) begin
                    state_n = IDLE;
                    if (bus.in_error) begin
                        err_inc = err_inc + 2'd1;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_n = wr_commit + PW'(1);
                        commit_n = wr_commit + PW'(1);
                        inc_pkt  = 1'b1;
                    end
                end else begin
                    wr_en    = 1'b1;
                    wr_ptr_n = wr_commit + PW'(1);
                    state_n  = RECV;
                end
            end else begin
                case (state)
                    IDLE: err_inc = 2'd1;
                    RECV: begin
                        if (full_wr) begin
                            inc_drop = 1'b1;
                            wr_ptr_n = wr_commit;
                            state_n  = bus.in_eop ? IDLE : DROP;
                        end else if (bus.in_eop) begin
                            state_n = IDLE;
                            if (bus.in_error) begin
                                err_inc  = 2'd1;
                                wr_ptr_n = wr_commit;
                            end else begin
                                wr_en    = 1'b1;
                                wr_ptr_n = wr_ptr + PW'(1);
                                commit_n = wr_ptr + PW'(1);
                                inc_pkt  = 1'b1;
                            end
                        end else begin
                            wr_en    = 1'b1;
                            wr_ptr_n = wr_ptr + PW'(1);
                        end
                    end
                    DROP:    if (bus.in_eop) state_n = IDLE;
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            wr_commit     <= '0;
            stat_pkt_cnt  <= '0;
            stat_drop_cnt <= '0;
            stat_err_cnt  <= '0;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_ptr_n;
            wr_commit <= commit_n;
            if (inc_pkt && stat_pkt_cnt != CNT_MAX) stat_pkt_cnt <= stat_pkt_cnt + CNT_W'(1);
            if (inc_drop && stat_drop_cnt != CNT_MAX) stat_drop_cnt <= stat_drop_cnt + CNT_W'(1);
            if (err_inc != 2'd0)
                stat_err_cnt <= (CNT_MAX - stat_err_cnt < CNT_W'(err_inc)) ? CNT_MAX
                                                                          : stat_err_cnt + CNT_W'(err_inc);
        end
    end

    tych_sdp_ram #(.DEPTH(DEPTH), .WIDTH($bits(entry_t))) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_entry),
        .re    (rd_issue),
        .raddr (fetch_ptr[AW-1:0]),
        .rdata (ram_q)
    );

    // Issue a read only if out + skid can absorb it next cycle, counting the beat already in flight.
    assign pop      = out_v & bus.out_ready;
    assign rd_issue = (fetch_ptr != wr_commit) &&
                      (({1'b0, out_v} + {1'b0, skid_v} + {1'b0, ram_vld} - {1'b0, pop}) <= 2'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr    <= '0;
            fetch_ptr <= '0;
            ram_vld   <= 1'b0;
            out_v     <= 1'b0;
            out_q     <= '0;
            skid_v    <= 1'b0;
            skid_q    <= '0;
        end else begin
            ram_vld <= rd_issue;
            if (rd_issue) fetch_ptr <= fetch_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (!out_v || pop) begin
                if (skid_v) begin
                    out_q <= skid_q;
                    out_v <= 1'b1;
                    if (ram_vld) skid_q <= ram_q;
                    else         skid_v <= 1'b0;
                end else if (ram_vld) begin
                    out_q <= ram_q;
                    out_v <= 1'b1;
                end else begin
                    out_v <= 1'b0;
                end
            end else if (ram_vld) begin
                skid_q <= ram_q;
                skid_v <= 1'b1;
            end
        end
    end

    assign bus.out_valid = out_v;
    assign bus.out_data  = out_q.data;
    assign bus.out_sop   = out_q.sop;
    assign bus.out_eop   = out_q.eop;
    assign bus.out_empty = out_q.empty;
    assign dbg_wstate    = state;
    assign dbg_used      = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_tych_rx_pktbuf.sv
// Directed and random checks of tych_rx_pktbuf with a 16-beat buffer.
module tb_tych_rx_pktbuf;
    import tych_rx_pktbuf_pkg::*;

    localparam int DW  = 64;
    localparam int EW  = 3;
    localparam int DEP = 16;
    localparam int CW  = 32;
    localparam int BW  = DW + 2 + EW;
    localparam int PW  = $clog2(DEP) + 1;

    logic          clk, rst;
    logic [CW-1:0] pkt_cnt, drop_cnt, err_cnt;
    rxbuf_wstate_t dbg_wstate;
    logic [PW-1:0] dbg_used;

    tych_rx_pktbuf_if #(.DWIDTH(DW), .EMPTY_W(EW)) bus ();

    tych_rx_pktbuf #(.DWIDTH(DW), .EMPTY_W(EW), .DEPTH(DEP), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .stat_pkt_cnt  (pkt_cnt),
        .stat_drop_cnt (drop_cnt),
        .stat_err_cnt  (err_cnt),
        .dbg_wstate    (dbg_wstate),
        .dbg_used      (dbg_used)
    );

    int total, bad, rx_beats, wr_beats, rdy_mode;
    bit valid_seen;
    logic [BW-1:0] exp_q[$];

    typedef struct {
        int             len;
        bit             err;
        bit             sop;
        logic [EW-1:0]  emp;
        bit             deliver;
        int             exp_pkt;
        int             exp_drop;
        int             exp_err;
    } vec_t;
    vec_t vecs[8];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic apply_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input bit s, input bit e,
                              input logic [EW-1:0] emp, input bit er);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sop   = s;
        bus.in_eop   = e;
        bus.in_empty = emp;
        bus.in_error = er;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_error = 1'b0;
    endtask

    task automatic send_pkt(input int len, input bit err, input bit with_sop, input bit with_eop,
                            input logic [EW-1:0] emp, input bit deliver, input bit gaps);
        for (int i = 0; i < len; i++) begin
            logic [DW-1:0] d;
            logic          s, e;
            logic [EW-1:0] em;
            d  = {$urandom, $urandom};
            s  = with_sop && (i == 0);
            e  = with_eop && (i == len - 1);
            em = e ? emp : '0;
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            drive_beat(d, s, e, em, e && err);
            if (deliver) exp_q.push_back({d, s, e, em});
        end
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        idle(4);
        while ((exp_q.size() != 0 || bus.out_valid) && n < 400) begin
            idle(1);
            n++;
        end
        check({nm, "_drain"}, (n < 400), 1);
    endtask

    // out_ready: 0 = held low, 1 = held high, 2 = 30% random
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 2) bus.out_ready = ($urandom_range(0, 99) < 30);
        else               bus.out_ready = (rdy_mode == 1);
    end

    // scoreboard / monitor
    logic [BW-1:0] prev_fields;
    bit            prev_stall;
    always @(negedge clk) begin
        logic [BW-1:0] cur;
        cur = {bus.out_data, bus.out_sop, bus.out_eop, bus.out_empty};
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.out_valid) valid_seen = 1'b1;
            if (prev_stall) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_hold", cur, prev_fields);
            end
            if (bus.out_valid && bus.out_ready) begin
                rx_beats++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h want none", cur);
                end else begin
                    check("beat", cur, exp_q.pop_front());
                end
            end
            prev_stall  = bus.out_valid && !bus.out_ready;
            prev_fields = cur;
        end
    end

    initial begin
        #600000;
        total++;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int lat, n_good, n_bad, tmo, mark, n;
        vecs[0] = '{4,  0, 1, 3'd3, 1, 2, 0, 0};
        vecs[1] = '{1,  0, 1, 3'd0, 1, 3, 0, 0};
        vecs[2] = '{8,  0, 1, 3'd5, 1, 4, 0, 0};
        vecs[3] = '{5,  1, 1, 3'd2, 0, 4, 0, 1};
        vecs[4] = '{2,  0, 1, 3'd6, 1, 5, 0, 1};
        vecs[5] = '{1,  0, 0, 3'd0, 0, 5, 0, 2};
        vecs[6] = '{20, 0, 1, 3'd1, 0, 5, 1, 2};
        vecs[7] = '{3,  0, 1, 3'd7, 1, 6, 1, 2};

        total = 0; bad = 0; rx_beats = 0; wr_beats = 0; rdy_mode = 1;
        valid_seen = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
        bus.in_empty = '0; bus.in_error = 1'b0; bus.out_ready = 1'b0;
        apply_reset();

        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_sop", bus.out_sop, 0);
        check("rst_out_eop", bus.out_eop, 0);
        check("rst_out_empty", bus.out_empty, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_wstate", dbg_wstate, IDLE);
        check("rst_used", dbg_used, 0);

        // first out_valid must appear within 2 edges of the committing edge
        send_pkt(4, 0, 1, 1, 3'd2, 1, 0);
        lat = 0;
        for (int k = 1; k <= 4; k++) begin
            idle(1);
            if (bus.out_valid && lat == 0) lat = k;
        end
        check("first_valid_lat_ok", (lat >= 1 && lat <= 2), 1);
        wait_drain("lat");
        check("lat_pkt_cnt", pkt_cnt, 1);

        for (int v = 0; v < 8; v++) begin
            valid_seen = 1'b0;
            send_pkt(vecs[v].len, vecs[v].err, vecs[v].sop, 1, vecs[v].emp, vecs[v].deliver, 0);
            wait_drain($sformatf("vec%0d", v));
            check($sformatf("vec%0d_pkt", v), pkt_cnt, vecs[v].exp_pkt);
            check($sformatf("vec%0d_drop", v), drop_cnt, vecs[v].exp_drop);
            check($sformatf("vec%0d_err", v), err_cnt, vecs[v].exp_err);
            if (!vecs[v].deliver) check($sformatf("vec%0d_no_valid", v), valid_seen, 0);
        end

        // overflow with the sink stalled: 10 committed, next 10 overflow
        rdy_mode = 0;
        idle(2);
        send_pkt(10, 0, 1, 1, 3'd4, 1, 0);
        send_pkt(10, 0, 1, 1, 3'd4, 0, 0);
        idle(4);
        check("ovf_drop", drop_cnt, 2);
        check("ovf_used", dbg_used, 10);
        check("ovf_valid", bus.out_valid, 1);
        mark = rx_beats;
        rdy_mode = 1;
        wait_drain("ovf");
        check("ovf_beats", rx_beats - mark, 10);
        check("ovf_pkt", pkt_cnt, 7);

        // sop in mid-packet abandons the open packet
        send_pkt(3, 0, 1, 0, 3'd0, 0, 0);
        send_pkt(4, 0, 1, 1, 3'd1, 1, 0);
        wait_drain("midsop");
        check("midsop_err", err_cnt, 3);
        check("midsop_pkt", pkt_cnt, 8);

        // random sink stalls with paced input so nothing overflows
        rdy_mode = 2;
        wr_beats = rx_beats;
        n_good = 0; n_bad = 0; tmo = 0;
        for (int p = 0; p < 1000; p++) begin
            int len;
            bit er;
            len = $urandom_range(1, 6);
            er  = ($urandom_range(0, 7) == 0);
            n = 0;
            while (wr_beats - rx_beats + len > DEP && n < 2000) begin
                idle(1);
                n++;
            end
            if (n >= 2000) tmo++;
            idle($urandom_range(0, 2));
            send_pkt(len, er, 1, 1, 3'($urandom_range(0, 7)), !er, 1);
            if (er) n_bad++;
            else begin
                n_good++;
                wr_beats += len;
            end
        end
        check("rand_space_wait", tmo, 0);
        rdy_mode = 1;
        wait_drain("rand");
        check("rand_pkt", pkt_cnt, 8 + n_good);
        check("rand_err", err_cnt, 3 + n_bad);
        check("rand_drop", drop_cnt, 2);

        // reset in mid-packet with a committed packet waiting
        rdy_mode = 0;
        idle(2);
        send_pkt(3, 0, 1, 1, 3'd3, 1, 0);
        idle(3);
        check("pre_rst_valid", bus.out_valid, 1);
        send_pkt(2, 0, 1, 0, 3'd0, 0, 0);
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_pkt", pkt_cnt, 0);
        check("mid_rst_drop", drop_cnt, 0);
        check("mid_rst_err", err_cnt, 0);
        check("mid_rst_wstate", dbg_wstate, IDLE);
        @(posedge clk);
        #1 rst = 1'b1;
        rdy_mode = 1;
        send_pkt(1, 0, 0, 1, 3'd0, 0, 0);
        send_pkt(2, 0, 1, 1, 3'd5, 1, 0);
        wait_drain("post_rst");
        check("post_rst_err", err_cnt, 1);
        check("post_rst_pkt", pkt_cnt, 1);
        check("post_rst_used", dbg_used, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tych_rx_pktbuf.md
Name: tych_rx_pktbuf

Overview:
Store-and-forward packet buffer between a MAC receive interface and the core ingress stage. The MAC receive interface has no backpressure; this block adds backpressure for the ingress stage.
- Accepts beats every cycle and commits only complete, error-free packets.
- Presents committed packets downstream with a valid/ready handshake.
- Packets that overflow the buffer or end with error are dropped whole; drops are counted.

Parameters:
DWIDTH, 64, data beat width in bits
EMPTY_W, 3, width of empty field; equals log2(DWIDTH/8)
DEPTH, 512, buffer depth in beats; power of two, at least 16
CNT_W, 32, statistics counter width

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-low reset
in_valid  input  1  MAC beat valid; no backpressure
in_data  input  DWIDTH  MAC beat data
in_sop  input  1  start of packet
in_eop  input  1  end of packet
in_empty  input  EMPTY_W  unused bytes on eop beat
in_error  input  1  packet error; sampled on eop beat only
out_valid  output  1  beat available
out_ready  input  1  downstream accepts beat
out_data  output  DWIDTH  beat data
out_sop  output  1  start of packet
out_eop  output  1  end of packet
out_empty  output  EMPTY_W  unused bytes on eop beat
stat_pkt_cnt  output  CNT_W  committed packets
stat_drop_cnt  output  CNT_W  packets dropped for overflow
stat_err_cnt  output  CNT_W  packets dropped for in_error or malformed framing

Behaviour:
- Reset (rst=0, asynchronous):
  - All pointers are 0.
  - Write FSM goes to IDLE.
  - out_valid, out_sop, out_eop, out_data and out_empty are 0.
  - All counters are 0.
  - RAM contents are don't-care.
- Pointers: wr_ptr, wr_commit and rd_ptr, each log2(DEPTH)+1 bits wide with natural wrap. used = wr_ptr - rd_ptr (modulo). full when used == DEPTH.
- RAM entry holds {data, sop, eop, empty}.
- Write FSM, evaluated only on in_valid beats:
  - IDLE:
    - sop=1 and not full: write the beat, wr_ptr++, go to RECV.
    - sop=1 and full: go to DROP, stat_drop_cnt++.
    - sop=0: discard the beat, stat_err_cnt++.
    - sop=1 and eop=1 (single-beat packet): handled as in RECV-eop below, in the same cycle.
  - RECV:
    - full: wr_ptr <= wr_commit, stat_drop_cnt++. Go to DROP, or to IDLE if this beat has eop.
    - eop=1 and error=0: write the beat, wr_commit <= wr_ptr+1, wr_ptr++, stat_pkt_cnt++, go to IDLE.
    - eop=1 and error=1: wr_ptr <= wr_commit, stat_err_cnt++, go to IDLE.
    - sop=1 (missing eop): wr_ptr <= wr_commit, stat_err_cnt++. Restart the new packet from the committed pointer and stay in RECV.
    - Otherwise: write the beat, wr_ptr++.
  - DROP: discard beats until an eop beat, then go to IDLE. A sop beat in DROP discards the partial packet and is handled as a sop in IDLE.
- Packets longer than DEPTH always take the overflow path.
- The full check uses the registered rd_ptr. A read in the same cycle does not free space for that cycle's write.
- Read side:
  - Only committed data is visible; data is available when rd_ptr != wr_commit.
  - Output register stage with prefetch. out_valid rises no later than 2 cycles after the edge that commits the eop beat when the buffer was empty.
  - Output fields hold stable while out_valid=1 and out_ready=0.
  - Transfer occurs when out_valid & out_ready. Sustained throughput is 1 beat per cycle with out_ready held at 1.
  - There are no bubbles inside a committed packet when out_ready=1.
- Counters saturate at all-ones and do not wrap.
- Simultaneous commit and read of the last committed beat: out_valid stays continuous. No beat is lost or duplicated.
- Reset mid-packet: the partial packet is discarded. The first post-reset beat without sop counts as an error.

Decomposition:
- core_structures package additions:
  - typedef rxbuf_entry_t {data, sop, eop, empty}
  - typedef enum rxbuf_wstate_t {IDLE, RECV, DROP}
  - constant TYCH_RXBUF_DEPTH
- Sub-module tych_sdp_ram: simple dual-port RAM, DEPTH x $bits(rxbuf_entry_t), one write port, registered read with 1-cycle latency, no reset on the array.

Test Plan:
- 3 packets of 4, 1 and 8 beats, out_ready=1:
  - outputs identical beats in order; sop/eop/empty preserved.
  - stat_pkt_cnt=3, other counters 0.
  - first out_valid ≤2 cycles after commit of the first eop.
- 5-beat packet with in_error=1 on eop, followed by a good 2-beat packet:
  - only the 2-beat packet appears.
  - stat_err_cnt=1, stat_pkt_cnt=1.
- DEPTH=16, out_ready=0; packets of 10 beats then 10 beats:
  - first is committed; second overflows.
  - stat_drop_cnt=1, used=10.
  - raising out_ready delivers exactly 10 beats.
- 20-beat packet with DEPTH=16 into an empty buffer: dropped, stat_drop_cnt=1, out_valid never asserts.
- Framing errors:
  - a beat without sop in IDLE: stat_err_cnt=1.
  - sop mid-packet after 3 beats: first packet discarded; second 4-beat packet delivered intact.
- Random out_ready at 30% over 1000 random packets with wraparound:
  - output stream equals scoreboard of committed packets.
  - stable-while-stalled assertions hold.
  - reset asserted mid-packet clears out_valid and all counters immediately.
